fibonacci_ctrl: RTL
===================

# fibonacci_ctrl

Register-mapped front-end that drives the Fibonacci engine from the SoC CSR bus. Software writes N and a START command. The block issues the single-cycle start pulse to the engine and tracks the engine's busy handshake with a timeout. Completed results go into a small result FIFO, and a maskable interrupt is raised on completion or timeout. It sits between the LiteX CSR bridge and the engine instance.

## Interface
- RES_DEPTH, 4, result FIFO depth (power of two, ≥2)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- bus_addr_i  in  3  word register index
- bus_we_i  in  1  write strobe, one cycle per access
- bus_wdata_i  in  32  write data
- bus_re_i  in  1  read strobe, one cycle per access
- bus_rdata_o  out  32  read data, registered
- fib_start_o  out  1  start pulse to engine
- fib_n_o  out  32  N to engine (REG_N contents)
- fib_busy_i  in  1  engine busy
- fib_result_i  in  32  engine result, valid when busy falls
- irq_o  out  1  level interrupt

## Operation
- Registers:
  - 0 N: RW. Writes are ignored unless the FSM is IDLE.
  - 1 CTRL: W. bit0 START; bit1 CLR (clears done/timeout/err sticky bits); bit2 IRQ_EN value. Reads return {29'b0, irq_en, 2'b0}.
  - 2 STATUS: R. bit0 active (FSM≠IDLE); bit1 done; bit2 timeout; bit3 err; bit4 fifo_full; [15:8] fifo count.
  - 3 RESULT: R. Pops the FIFO head. When empty it returns 0 and does not pop.
  - 4 TIMEOUT: RW cycle limit. 0 disables the timeout.
  - Addresses 5–7 read 0; writes to them are ignored.
- FSM states: IDLE, LAUNCH, WAIT_ACK, RUN.
  - IDLE→LAUNCH on START when the FIFO is not full.
  - START while not IDLE, or while the FIFO is full, is ignored and sets err.
  - LAUNCH: fib_start_o=1 for exactly this cycle. Always goes to WAIT_ACK.
  - WAIT_ACK: fib_busy_i=1 → RUN.
  - RUN: fib_busy_i=0 → push fib_result_i, set done, go to IDLE.
- Timeout:
  - A 32-bit cycle counter clears on LAUNCH and increments in WAIT_ACK and RUN.
  - If TIMEOUT≠0 and counter==TIMEOUT: set timeout, go to IDLE, no push.
- Engine contract:
  - The engine samples start in its idle state.
  - It asserts busy the cycle after start and holds it for ≥1 cycle.
  - Its result is stable from the first busy-low cycle.
  - Arithmetic wraps mod 2^32 inside the engine; this block passes the value through untouched.
- irq_o = irq_en & (done | timeout).
- CTRL write with CLR and START together: CLR applies first, then START is evaluated. An err produced by that START remains set.
- FIFO push and pop in the same cycle: both take effect and the count is unchanged. A pop on an empty FIFO is a no-op.

## Timing
- Reset values:
  - Outputs: bus_rdata_o=0, fib_start_o=0, fib_n_o=0, irq_o=0.
  - Internal: all registers 0, FSM IDLE, FIFO empty.
- Reset mid-operation aborts immediately. fib_busy_i is ignored until the next LAUNCH.
- Read latency: bus_rdata_o is valid the cycle after bus_re_i and holds until the next read.
  - A RESULT pop takes effect at the same edge that registers the data.
- START written at edge t: LAUNCH during cycle t+1 (fib_start_o high), WAIT_ACK from t+2.
- Completion: the result is pushed at the edge ending the first busy-low cycle in RUN.
  - done, count and irq_o update in the following cycle.
- A read and a write in the same cycle are both honoured. A read of a register returns its value from before the write.

## Structure
- Package fib_pkg holds:
  - register index constants
  - CTRL/STATUS bit positions
  - state_t enum {IDLE, LAUNCH, WAIT_ACK, RUN}
- Sub-module fib_result_fifo: synchronous FIFO with parameters WIDTH and DEPTH, and ports push, pop, din, dout, count, full, empty.
  - dout shows the head combinationally.

## Test plan
- N=10, START: fib_start_o high exactly 1 cycle. STATUS.done=1, count=1. RESULT read returns 55. Count returns to 0.
- N=0 then N=1, each with START: reads return 0 then 1. No spurious second start pulse.
- Four jobs N=1..4 with no reads: count=4, fifo_full=1. A fifth START is ignored and err=1. Reads return 1, 1, 2, 3, then 0 on empty.
- Stub engine holds busy high, TIMEOUT=20, IRQ_EN=1:
  - timeout=1 and irq_o=1 at 20 counted cycles after LAUNCH; FIFO count unchanged.
  - CLR drops irq_o the next cycle.
- Assert rst_ni during RUN with N=40: all outputs 0 and STATUS reads 0 after release. A new N=5 job returns 5.
- Read RESULT in the same cycle as a completion push with count=1: the old head is returned and count stays 1. The next read returns the new result.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state type for the
// Fibonacci engine CSR front-end.
package fib_pkg;

  localparam logic [2:0] REG_N       = 3'd0;
  localparam logic [2:0] REG_CTRL    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_RESULT  = 3'd3;
  localparam logic [2:0] REG_TIMEOUT = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_ACTIVE  = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_FULL    = 4;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2,
    RUN      = 2'd3
  } state_t;

endpackage

// File: rtl/fib_result_fifo.sv
// Small synchronous result FIFO; the head is visible combinationally on dout.
module fib_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  // A pop frees the head slot at the same edge, so a push into a full FIFO is allowed then.
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & ~empty;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fibonacci_ctrl.sv
// CSR front-end for the Fibonacci engine: launches jobs, tracks the busy
// handshake with a timeout, queues results and raises a maskable interrupt.
module fibonacci_ctrl
  import fib_pkg::*;
#(
  parameter int RES_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  bus_addr_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_wdata_i,
  input  logic        bus_re_i,
  output logic [31:0] bus_rdata_o,
  output logic        fib_start_o,
  output logic [31:0] fib_n_o,
  input  logic        fib_busy_i,
  input  logic [31:0] fib_result_i,
  output logic        irq_o
);

  localparam int CW = $clog2(RES_DEPTH) + 1;

  state_t      state_r;
  logic [31:0] n_r;
  logic [31:0] tmo_lim_r;
  logic [31:0] cyc_r;
  logic        irq_en_r;
  logic        done_r;
  logic        tmo_r;
  logic        err_r;

  logic [31:0] fifo_dout_s;
  logic [CW-1:0] fifo_count_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;

  logic        wr_ctrl_s;
  logic        start_cmd_s;
  logic        clr_s;
  logic        launch_ok_s;
  logic        start_err_s;
  logic        complete_s;
  logic        tmo_hit_s;
  logic        pop_s;
  logic        done_d_s;
  logic        tmo_d_s;
  logic        err_d_s;
  logic        irq_en_d_s;
  logic [31:0] status_s;
  logic [31:0] rdata_s;

  assign fib_n_o     = n_r;
  assign wr_ctrl_s   = bus_we_i && (bus_addr_i == REG_CTRL);
  assign start_cmd_s = wr_ctrl_s && bus_wdata_i[CTRL_START];
  assign clr_s       = wr_ctrl_s && bus_wdata_i[CTRL_CLR];
  assign launch_ok_s = start_cmd_s && (state_r == IDLE) && !fifo_full_s;
  assign start_err_s = start_cmd_s && !launch_ok_s;
  assign complete_s  = (state_r == RUN) && !fib_busy_i;
  // A completion seen in the same cycle as the limit wins over the timeout.
  assign tmo_hit_s   = ((state_r == WAIT_ACK) || (state_r == RUN)) && (tmo_lim_r != 32'd0)
                       && (cyc_r == tmo_lim_r) && !complete_s;
  assign pop_s       = bus_re_i && (bus_addr_i == REG_RESULT) && !fifo_empty_s;

  // CLR clears the sticky bits first, so events in the same cycle still set them.
  assign done_d_s    = (done_r & ~clr_s) | complete_s;
  assign tmo_d_s     = (tmo_r & ~clr_s) | tmo_hit_s;
  assign err_d_s     = (err_r & ~clr_s) | start_err_s;
  assign irq_en_d_s  = wr_ctrl_s ? bus_wdata_i[CTRL_IRQ_EN] : irq_en_r;

  assign status_s = {16'd0, 8'(fifo_count_s), 3'd0, fifo_full_s, err_r, tmo_r, done_r,
                     (state_r != IDLE)};

  // Read-data mux over the pre-write register values.
  always_comb begin
    rdata_s = 32'd0;
    case (bus_addr_i)
      REG_N:       rdata_s = n_r;
      REG_CTRL:    rdata_s = {29'd0, irq_en_r, 2'd0};
      REG_STATUS:  rdata_s = status_s;
      REG_RESULT:  rdata_s = fifo_empty_s ? 32'd0 : fifo_dout_s;
      REG_TIMEOUT: rdata_s = tmo_lim_r;
      default:     rdata_s = 32'd0;
    endcase
  end

  // Job FSM, CSR state and registered bus/engine/interrupt outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      n_r         <= 32'd0;
      tmo_lim_r   <= 32'd0;
      cyc_r       <= 32'd0;
      irq_en_r    <= 1'b0;
      done_r      <= 1'b0;
      tmo_r       <= 1'b0;
      err_r       <= 1'b0;
      bus_rdata_o <= 32'd0;
      fib_start_o <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (bus_we_i && (bus_addr_i == REG_N) && (state_r == IDLE)) begin
        n_r <= bus_wdata_i;
      end
      if (bus_we_i && (bus_addr_i == REG_TIMEOUT)) begin
        tmo_lim_r <= bus_wdata_i;
      end
      if (bus_re_i) begin
        bus_rdata_o <= rdata_s;
      end
      done_r      <= done_d_s;
      tmo_r       <= tmo_d_s;
      err_r       <= err_d_s;
      irq_en_r    <= irq_en_d_s;
      irq_o       <= irq_en_d_s & (done_d_s | tmo_d_s);
      fib_start_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (launch_ok_s) begin
            state_r     <= LAUNCH;
            fib_start_o <= 1'b1;
          end
        end
        LAUNCH: begin
          state_r <= WAIT_ACK;
          cyc_r   <= 32'd0;
        end
        WAIT_ACK: begin
          cyc_r <= cyc_r + 32'd1;
          if (tmo_hit_s) begin
            state_r <= IDLE;
          end else if (fib_busy_i) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          cyc_r <= cyc_r + 32'd1;
          if (complete_s || tmo_hit_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  fib_result_fifo #(
    .WIDTH (32),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (complete_s),
    .pop    (pop_s),
    .din    (fib_result_i),
    .dout   (fifo_dout_s),
    .count  (fifo_count_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

endmodule
